// File: rtl/bch_syndrome_stream.sv
// Streaming BCH syndrome generator: folds LANES hard decisions per beat into
// S1..S2t with a parallel Horner step, and tracks the least-reliable position.
module bch_syndrome_stream #(
   parameter int LANES = 8,
   parameter int LLR_W = 8,
   parameter int M_MAX = 10,
   parameter int NSYN  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   set,
   input  logic                   mode,
   input  logic [1:0]             code,
   input  logic [LANES*LLR_W-1:0] idata,
   output logic                   ready,
   output logic                   syn_valid,
   output logic [NSYN*M_MAX-1:0]  syndrome,
   output logic                   syn_zero,
   output logic [LLR_W-2:0]       min_mag,
   output logic [9:0]             min_idx
);

   typedef logic [M_MAX-1:0] elem_t;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0] FLD6  = 2'd0;
   localparam logic [1:0] FLD8  = 2'd1;
   localparam logic [1:0] FLD10 = 2'd2;
   localparam elem_t      ZERO  = {M_MAX{1'b0}};

   localparam logic [7:0] BEATS6  = 8'(64 / LANES);
   localparam logic [7:0] BEATS8  = 8'(256 / LANES);
   localparam logic [7:0] BEATS10 = 8'(1024 / LANES);

   localparam logic [NSYN-1:0] ACT_T2 = NSYN'(4'hF);
   localparam logic [NSYN-1:0] ACT_T4 = {NSYN{1'b1}};

   // Multiply by alpha in the selected field; bits above m stay zero.
   function automatic elem_t gf_xtime(input elem_t a, input logic [1:0] fld);
      elem_t r;
      case (fld)
         FLD6:    r = ((a << 1) & elem_t'(10'h03F)) ^ (a[5] ? elem_t'(10'h003) : ZERO);
         FLD8:    r = ((a << 1) & elem_t'(10'h0FF)) ^ (a[7] ? elem_t'(10'h01D) : ZERO);
         default: r = ((a << 1) & elem_t'(10'h3FF)) ^ (a[9] ? elem_t'(10'h009) : ZERO);
      endcase
      return r;
   endfunction

   function automatic elem_t gf_mul(input elem_t a, input elem_t b, input logic [1:0] fld);
      elem_t r;
      r = ZERO;
      for (int k = M_MAX - 1; k >= 0; k--) begin
         r = gf_xtime(r, fld) ^ (b[k] ? a : ZERO);
      end
      return r;
   endfunction

   function automatic elem_t alpha_pow(input int e, input logic [1:0] fld);
      elem_t r;
      r = elem_t'(10'h001);
      for (int k = 0; k < e; k++) begin
         r = gf_xtime(r, fld);
      end
      return r;
   endfunction

   // Saturating magnitude: the most negative code maps to the largest magnitude.
   function automatic logic [LLR_W-2:0] llr_mag(input logic [LLR_W-1:0] v);
      logic [LLR_W-1:0] neg;
      neg = (~v) + {{(LLR_W-1){1'b0}}, 1'b1};
      return v[LLR_W-1] ? (neg[LLR_W-1] ? {(LLR_W-1){1'b1}} : neg[LLR_W-2:0])
                        : v[LLR_W-2:0];
   endfunction

   state_t                      state_r, state_nx_s;
   logic                        mode_r, first_r, ready_r, syn_valid_r, syn_zero_r;
   logic [1:0]                  fld_r, fld_s;
   logic [NSYN-1:0]             act_r, act_s;
   logic [7:0]                  cnt_r, beats_s;
   logic [NSYN-1:0][M_MAX-1:0]  syn_r, syn_next_s;
   logic [LLR_W-2:0]            min_mag_r, cand_mag_s;
   logic [9:0]                  min_idx_r, cand_idx_s, base_s;
   logic [LANES-1:0]            hard_s;
   logic                        last_s;

   assign last_s = (cnt_r == 8'd1);
   assign base_s = 10'(cnt_r - 8'd1) * 10'(LANES);

   // Decode the code selector into field, beat count and active syndromes.
   always_comb begin
      fld_s   = FLD10;
      beats_s = BEATS10;
      act_s   = ACT_T4;
      case (code)
         2'd1: begin
            fld_s   = FLD6;
            beats_s = BEATS6;
            act_s   = ACT_T2;
         end
         2'd2: begin
            fld_s   = FLD8;
            beats_s = BEATS8;
            act_s   = ACT_T2;
         end
         default: begin
            fld_s   = FLD10;
            beats_s = BEATS10;
            act_s   = ACT_T4;
         end
      endcase
   end

   // Hard decisions; the padding position in the first beat's top lane is forced to 0.
   always_comb begin
      hard_s = {LANES{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         hard_s[l] = idata[l*LLR_W + LLR_W - 1];
      end
      hard_s[LANES-1] = idata[LANES*LLR_W - 1] & ~first_r;
   end

   for (genvar gi = 0; gi < NSYN; gi++) begin : g_syn
      localparam int    IDX    = gi + 1;
      localparam elem_t STEP6  = alpha_pow(IDX * LANES, FLD6);
      localparam elem_t STEP8  = alpha_pow(IDX * LANES, FLD8);
      localparam elem_t STEP10 = alpha_pow(IDX * LANES, FLD10);

      elem_t lane_t_s [LANES];
      elem_t step_s, next_s;

      for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
         localparam elem_t LC6  = alpha_pow(IDX * gl, FLD6);
         localparam elem_t LC8  = alpha_pow(IDX * gl, FLD8);
         localparam elem_t LC10 = alpha_pow(IDX * gl, FLD10);
         assign lane_t_s[gl] = !hard_s[gl]     ? ZERO :
                               (fld_r == FLD6) ? LC6  :
                               (fld_r == FLD8) ? LC8  : LC10;
      end

      // One Horner step: scale by alpha^(i*LANES), then add this beat's lanes.
      always_comb begin
         step_s = STEP10;
         case (fld_r)
            FLD6:    step_s = STEP6;
            FLD8:    step_s = STEP8;
            default: step_s = STEP10;
         endcase
         next_s = gf_mul(syn_r[gi], step_s, fld_r);
         for (int l = 0; l < LANES; l++) begin
            next_s = next_s ^ lane_t_s[l];
         end
      end

      assign syn_next_s[gi] = act_r[gi] ? next_s : ZERO;
   end

   // Running minimum: scan high lane first with strict compare so ties keep the higher position.
   always_comb begin
      cand_mag_s = min_mag_r;
      cand_idx_s = min_idx_r;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (!(first_r && (l == LANES - 1)) &&
             (llr_mag(idata[l*LLR_W +: LLR_W]) < cand_mag_s)) begin
            cand_mag_s = llr_mag(idata[l*LLR_W +: LLR_W]);
            cand_idx_s = base_s + 10'(l);
         end else begin
            cand_mag_s = cand_mag_s;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (set) begin
               state_nx_s = LOAD;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LOAD: begin
            if (last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = LOAD;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Datapath: start latching, per-beat accumulation and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r      <= 1'b0;
         fld_r       <= FLD10;
         act_r       <= {NSYN{1'b0}};
         cnt_r       <= 8'd0;
         first_r     <= 1'b0;
         ready_r     <= 1'b0;
         syn_valid_r <= 1'b0;
         syn_zero_r  <= 1'b0;
         syn_r       <= {(NSYN*M_MAX){1'b0}};
         min_mag_r   <= {(LLR_W-1){1'b1}};
         min_idx_r   <= 10'd0;
      end else begin
         syn_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (set) begin
                  mode_r     <= mode;
                  fld_r      <= fld_s;
                  act_r      <= act_s;
                  cnt_r      <= beats_s;
                  first_r    <= 1'b1;
                  ready_r    <= 1'b1;
                  syn_zero_r <= 1'b0;
                  syn_r      <= {(NSYN*M_MAX){1'b0}};
                  min_mag_r  <= {(LLR_W-1){1'b1}};
                  min_idx_r  <= 10'd0;
               end else begin
                  ready_r <= 1'b0;
               end
            end
            LOAD: begin
               syn_r   <= syn_next_s;
               first_r <= 1'b0;
               cnt_r   <= cnt_r - 8'd1;
               if (mode_r) begin
                  min_mag_r <= cand_mag_s;
                  min_idx_r <= cand_idx_s;
               end else begin
                  min_mag_r <= min_mag_r;
               end
               if (last_s) begin
                  ready_r     <= 1'b0;
                  syn_valid_r <= 1'b1;
                  syn_zero_r  <= ~|syn_next_s;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            default: begin
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign ready     = ready_r;
   assign syn_valid = syn_valid_r;
   assign syndrome  = syn_r;
   assign syn_zero  = syn_zero_r;
   assign min_mag   = min_mag_r;
   assign min_idx   = min_idx_r;

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Scoreboard bench for bch_syndrome_stream: directed codewords with hand-computed
// syndromes; a monitor pops expectations on every syn_valid pulse.
module tb_bch_syndrome_stream;

   localparam int LANES = 8;
   localparam int LLR_W = 8;
   localparam int M_MAX = 10;
   localparam int NSYN  = 8;

   typedef struct {
      logic [79:0] syn;
      logic        zero;
      logic [6:0]  mag;
      logic [9:0]  idx;
      int          beats;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   set;
   logic                   mode;
   logic [1:0]             code;
   logic [LANES*LLR_W-1:0] idata;
   logic                   ready;
   logic                   syn_valid;
   logic [NSYN*M_MAX-1:0]  syndrome;
   logic                   syn_zero;
   logic [LLR_W-2:0]       min_mag;
   logic [9:0]             min_idx;

   exp_t              exp_q[$];
   int                checks = 0;
   int                errors = 0;
   int                ready_cnt = 0;
   logic              valid_prev = 1'b0;
   logic signed [7:0] llr [0:1023];

   always #5 clk = ~clk;

   bch_syndrome_stream #(.LANES(LANES), .LLR_W(LLR_W), .M_MAX(M_MAX), .NSYN(NSYN)) dut (
      .clk(clk), .rst(rst), .set(set), .mode(mode), .code(code), .idata(idata),
      .ready(ready), .syn_valid(syn_valid), .syndrome(syndrome), .syn_zero(syn_zero),
      .min_mag(min_mag), .min_idx(min_idx)
   );

   function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endfunction

   function automatic logic [79:0] pk(input logic [9:0] s1, input logic [9:0] s2,
                                      input logic [9:0] s3, input logic [9:0] s4,
                                      input logic [9:0] s5, input logic [9:0] s6,
                                      input logic [9:0] s7, input logic [9:0] s8);
      return {s8, s7, s6, s5, s4, s3, s2, s1};
   endfunction

   function automatic exp_t mk(input logic [79:0] s, input logic z, input logic [6:0] m,
                               input logic [9:0] i, input int b);
      exp_t e;
      e.syn = s; e.zero = z; e.mag = m; e.idx = i; e.beats = b;
      return e;
   endfunction

   task automatic fill(input logic signed [7:0] v);
      for (int p = 0; p < 1024; p++) llr[p] = v;
   endtask

   // Issue one codeword; glitch_beat pulses set mid-load, abort_beat asserts rst.
   task automatic run(input int c, input logic md, input int glitch_beat, input int abort_beat,
                      input exp_t e, input logic push);
      int n;
      int beats;
      n     = (c == 1) ? 63 : (c == 2) ? 255 : 1023;
      beats = (n + 1) / LANES;
      @(negedge clk);
      set  = 1'b1;
      code = 2'(c);
      mode = md;
      if (push) exp_q.push_back(e);
      for (int b = 0; b < beats; b++) begin
         @(negedge clk);
         set = (b == glitch_beat);
         if (b == abort_beat) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort_ready", 80'(ready), 80'(0));
            chk("abort_syndrome", 80'(syndrome), 80'(0));
            chk("abort_valid", 80'(syn_valid), 80'(0));
            chk("abort_min_mag", 80'(min_mag), 80'(7'h7F));
            rst = 1'b0;
            set = 1'b0;
            return;
         end
         for (int l = 0; l < LANES; l++) begin
            idata[l*LLR_W +: LLR_W] = llr[n - LANES*b - (LANES - 1 - l)];
         end
      end
      @(negedge clk);
      set   = 1'b0;
      idata = '0;
      for (int k = 0; k < 6; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("valid_timeout_pending", 80'(exp_q.size()), 80'(0));
      exp_q.delete();
      @(negedge clk);
   endtask

   // Monitor: counts ready cycles and compares results at every syn_valid pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            ready_cnt  = 0;
            valid_prev = 1'b0;
         end else begin
            if (ready === 1'b1) ready_cnt++;
            if (syn_valid === 1'b1) begin
               chk("valid_pulse_width", 80'(valid_prev), 80'(0));
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got syn_valid=1 expected no result");
               end else begin
                  e = exp_q.pop_front();
                  chk("syndrome", 80'(syndrome), e.syn);
                  chk("syn_zero", 80'(syn_zero), 80'(e.zero));
                  chk("min_mag", 80'(min_mag), 80'(e.mag));
                  chk("min_idx", 80'(min_idx), 80'(e.idx));
                  chk("ready_cycles", 80'(ready_cnt), 80'(e.beats));
                  chk("ready_low_at_valid", 80'(ready), 80'(0));
               end
               ready_cnt = 0;
            end
            valid_prev = syn_valid;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      exp_t e_c3;
      rst   = 1'b1;
      set   = 1'b0;
      mode  = 1'b0;
      code  = 2'd0;
      idata = '0;
      repeat (2) @(negedge clk);
      chk("reset_ready", 80'(ready), 80'(0));
      chk("reset_valid", 80'(syn_valid), 80'(0));
      chk("reset_zero", 80'(syn_zero), 80'(0));
      chk("reset_syndrome", 80'(syndrome), 80'(0));
      chk("reset_min_mag", 80'(min_mag), 80'(7'h7F));
      chk("reset_min_idx", 80'(min_idx), 80'(0));
      rst = 1'b0;

      fill(8'sd100);
      run(1, 1'b0, -1, -1, mk(80'(0), 1'b1, 7'h7F, 10'd0, 8), 1'b1);

      fill(8'sd50);
      llr[0] = -8'sd5;
      e_c3 = mk(pk(10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001),
                1'b0, 7'h7F, 10'd0, 128);
      run(3, 1'b0, -1, -1, e_c3, 1'b1);

      fill(8'sd100);
      llr[1] = -8'sd100;
      run(1, 1'b0, -1, -1, mk(pk(10'h002, 10'h004, 10'h008, 10'h010, 10'h0, 10'h0, 10'h0, 10'h0),
                               1'b0, 7'h7F, 10'd0, 8), 1'b1);

      fill(8'sd100);
      llr[8] = -8'sd100;
      run(2, 1'b0, -1, -1, mk(pk(10'h01D, 10'h04C, 10'h08F, 10'h09D, 10'h0, 10'h0, 10'h0, 10'h0),
                               1'b0, 7'h7F, 10'd0, 32), 1'b1);

      fill(8'sd100);
      llr[40] = 8'sd3;
      llr[5]  = -8'sd3;
      run(1, 1'b1, -1, -1, mk(pk(10'h020, 10'h030, 10'h028, 10'h03C, 10'h0, 10'h0, 10'h0, 10'h0),
                               1'b0, 7'd3, 10'd40, 8), 1'b1);
      run(1, 1'b0, -1, -1, mk(pk(10'h020, 10'h030, 10'h028, 10'h03C, 10'h0, 10'h0, 10'h0, 10'h0),
                               1'b0, 7'h7F, 10'd0, 8), 1'b1);

      fill(-8'sd100);
      run(1, 1'b1, -1, -1, mk(80'(0), 1'b1, 7'd100, 10'd62, 8), 1'b1);

      fill(-8'sd128);
      run(1, 1'b1, -1, -1, mk(80'(0), 1'b1, 7'h7F, 10'd0, 8), 1'b1);

      fill(8'sd100);
      llr[8] = -8'sd100;
      run(2, 1'b0, 5, -1, mk(pk(10'h01D, 10'h04C, 10'h08F, 10'h09D, 10'h0, 10'h0, 10'h0, 10'h0),
                              1'b0, 7'h7F, 10'd0, 32), 1'b1);

      fill(8'sd50);
      llr[0] = -8'sd5;
      run(3, 1'b0, -1, 10, e_c3, 1'b0);
      repeat (140) @(negedge clk);
      run(3, 1'b0, -1, -1, e_c3, 1'b1);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
